// File: rtl/fp_mult_txn_resp.sv
// fp_mult_txn_resp: responder-side valid/ready front end for the fixed-latency FP multiplier.
// Optional feature macro: FPM_RND_CHECK_EN (rejects rounding modes 6/7 with a NaN + err result).
// Contains the small result FIFO (fp_mult_txn_resp_fifo) and the top (fp_mult_txn_resp).

// Purpose: generic power-of-two FIFO holding completed results in arrival order.
// Latency: push visible on o_dat/o_cnt after one edge; head is read combinationally from storage.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module fp_mult_txn_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_dat,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_dat,
   output logic [$clog2(DEPTH):0] o_cnt
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_cnt;

   // Storage write; cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push) begin
         r_mem[r_wr_ptr] <= i_dat;
      end
   end

   // Pointers wrap naturally (power-of-two depth); count holds on simultaneous push and pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_dat = r_mem[r_rd_ptr];
   assign o_cnt = r_cnt;

endmodule

// Purpose: accept operand requests, issue them to the multiplier, return z/status/tag in order.
// Latency: accept at E0 -> mul_* valid after E0, result on out_* after E0+LATENCY+1.
// Backpressure: in_ready is credit-gated (queued + in-flight < FIFO_DEPTH); no result is ever dropped.
module fp_mult_txn_resp #(
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [2:0]  in_rnd,
   input  logic [3:0]  in_tag,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic [2:0]  mul_rnd,
   output logic        mul_issue,
   input  logic [31:0] mul_z,
   input  logic [7:0]  mul_status,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_z,
   output logic [7:0]  out_status,
   output logic [3:0]  out_tag,
   output logic        out_err
);
   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_V = FIFO_DEPTH[CW:0];
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef struct packed {
      logic [31:0] z;
      logic [7:0]  status;
      logic [3:0]  tag;
      logic        err;
   } res_t;

   logic          w_accept;
   logic          w_rnd_bad;
   logic          w_exit;
   logic          w_pop;
   logic [CW-1:0] w_fifo_cnt;
   logic [CW:0]   w_used;
   res_t          w_push_dat;
   res_t          w_head;

   logic [CW-1:0] r_inflight;
   logic          r_pipe_vld [0:LATENCY];
   logic [3:0]    r_pipe_tag [0:LATENCY];
   logic          r_pipe_err [0:LATENCY];
   logic [31:0]   r_mul_a;
   logic [31:0]   r_mul_b;
   logic [2:0]    r_mul_rnd;
   logic          r_mul_issue;

`ifdef FPM_RND_CHECK_EN
   // Rounding modes 6 and 7 are undefined: the request keeps its slot but never reaches the core.
   assign w_rnd_bad = (in_rnd[2:1] == 2'b11);
`else
   // Without checking every mode passes through, so the err bit carried in the FIFO is always 0.
   assign w_rnd_bad = 1'b0;
`endif

   // Credits come only from registered counters (plus reset), so in_ready has no path from in_valid.
   assign w_used   = {1'b0, w_fifo_cnt} + {1'b0, r_inflight};
   assign in_ready = rst && (w_used < DEPTH_V);
   assign w_accept = in_valid && in_ready;
   assign w_exit   = r_pipe_vld[LATENCY];

   // Register operands into the core for legal requests; they hold their last value while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_mul_rnd   <= '0;
         r_mul_issue <= 1'b0;
      end else begin
         r_mul_issue <= w_accept && !w_rnd_bad;
         if (w_accept && !w_rnd_bad) begin
            r_mul_a   <= in_a;
            r_mul_b   <= in_b;
            r_mul_rnd <= in_rnd;
         end
      end
   end

   // Tag/valid shift pipeline, LATENCY+1 deep, tracking the core's fixed latency plus operand register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k <= LATENCY; k++) begin
            r_pipe_vld[k] <= 1'b0;
            r_pipe_tag[k] <= '0;
            r_pipe_err[k] <= 1'b0;
         end
      end else begin
         r_pipe_vld[0] <= w_accept;
         r_pipe_tag[0] <= in_tag;
         r_pipe_err[0] <= w_accept && w_rnd_bad;
         for (int k = 1; k <= LATENCY; k++) begin
            r_pipe_vld[k] <= r_pipe_vld[k-1];
            r_pipe_tag[k] <= r_pipe_tag[k-1];
            r_pipe_err[k] <= r_pipe_err[k-1];
         end
      end
   end

   // In-flight counter: accepted but not yet written to the FIFO; accept+exit together cancel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inflight <= '0;
      end else begin
         case ({w_accept, w_exit})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Build the FIFO entry at pipeline exit; rejected requests get a quiet NaN with err set.
   always_comb begin
      w_push_dat.z      = mul_z;
      w_push_dat.status = mul_status;
      w_push_dat.tag    = r_pipe_tag[LATENCY];
      w_push_dat.err    = 1'b0;
      if (r_pipe_err[LATENCY]) begin
         w_push_dat.z      = QNAN;
         w_push_dat.status = '0;
         w_push_dat.err    = 1'b1;
      end
   end

   fp_mult_txn_resp_fifo #(
      .WIDTH ($bits(res_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_exit),
      .i_dat   (w_push_dat),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_cnt   (w_fifo_cnt)
   );

   assign out_valid  = (w_fifo_cnt != '0);
   assign w_pop      = out_valid && out_ready;
   assign out_z      = w_head.z;
   assign out_status = w_head.status;
   assign out_tag    = w_head.tag;
   assign out_err    = w_head.err;

   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;
   assign mul_rnd    = r_mul_rnd;
   assign mul_issue  = r_mul_issue;

endmodule

// File: tb/tb_fp_mult_txn_resp.sv
// Bench for fp_mult_txn_resp: random operands through a stand-in multiplier core, in-order scoreboard,
// plus directed steps for reset, single request, back-pressure, streaming, push/pop, reset, rnd check.
module tb_fp_mult_txn_resp;
   localparam int LAT   = 2;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [2:0]  in_rnd;
   logic [3:0]  in_tag;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [2:0]  mul_rnd;
   logic        mul_issue;
   logic [31:0] mul_z;
   logic [7:0]  mul_status;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_z;
   logic [7:0]  out_status;
   logic [3:0]  out_tag;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_mult_txn_resp #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_rnd     (in_rnd),
      .in_tag     (in_tag),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_rnd    (mul_rnd),
      .mul_issue  (mul_issue),
      .mul_z      (mul_z),
      .mul_status (mul_status),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_z      (out_z),
      .out_status (out_status),
      .out_tag    (out_tag),
      .out_err    (out_err)
   );

   // Stand-in core: truncating multiply of normal numbers, status = {inexact, rnd}.
   function automatic logic [39:0] fmul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      logic        inx;
      p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (p[47]) begin
         m   = p[46:24];
         inx = |p[23:0];
         e   = e + 10'd1;
      end else begin
         m   = p[45:23];
         inx = |p[22:0];
      end
      return {a[31] ^ b[31], e[7:0], m, 4'b0, inx, rnd};
   endfunction

   // Reference: what the consumer must see for a request, {z, status, tag, err}.
   function automatic logic [44:0] expect_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] rnd, input logic [3:0] tag);
      logic [39:0] r;
`ifdef FPM_RND_CHECK_EN
      if (rnd >= 3'd6) return {32'h7FC0_0000, 8'h00, tag, 1'b1};
`endif
      r = fmul(a, b, rnd);
      return {r, tag, 1'b0};
   endfunction

   // Stand-in core pipeline: LAT register stages from mul_* to mul_z/mul_status.
   logic [39:0] r_core [1:LAT];
   always @(posedge clk) begin
      r_core[1] <= fmul(mul_a, mul_b, mul_rnd);
      for (int k = 2; k <= LAT; k++) r_core[k] <= r_core[k-1];
   end
   assign {mul_z, mul_status} = r_core[LAT];

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] r;
      r = $urandom;
      r[30:23] = 8'($urandom_range(100, 154));
      return r;
   endfunction

   task automatic set_req(input logic [3:0] tag, input logic [2:0] rnd);
      in_valid = 1'b1;
      in_a     = rnd_op();
      in_b     = rnd_op();
      in_rnd   = rnd;
      in_tag   = tag;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: handshakes sampled mid-cycle; queue cleared while reset is asserted.
   logic [44:0] exp_q [$];
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               chk("sb_result", 64'({out_z, out_status, out_tag, out_err}), 64'(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(expect_res(in_a, in_b, in_rnd, in_tag));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc;
      int          blocked;
      int          stalls;
      int          seen;
      logic        acc_now;
      logic [31:0] a1;
      logic [44:0] exp2;

      rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = '0; in_tag = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      chk("rst_mul_rnd_issue", 64'({mul_rnd, mul_issue}), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_fields", 64'({out_z, out_status, out_tag, out_err}), 64'd0);

      step(); rst = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", 64'(in_ready), 64'd1);

      // Single request: 1.0 * 2.0, tag 5
      step();
      in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_rnd = 3'd0; in_tag = 4'd5;
      step(); in_valid = 1'b0;                             // E0 done
      @(negedge clk);
      chk("single_issue_hi", 64'(mul_issue), 64'd1);
      chk("single_mul_ops", 64'({mul_a, mul_b}), 64'h3F80_0000_4000_0000);
      @(negedge clk);                                      // after E1
      chk("single_issue_lo", 64'(mul_issue), 64'd0);
      chk("single_valid_e1", 64'(out_valid), 64'd0);
      @(negedge clk);                                      // after E2
      chk("single_valid_e2", 64'(out_valid), 64'd0);
      @(negedge clk);                                      // after E3
      chk("single_valid_e3", 64'(out_valid), 64'd1);
      chk("single_result", 64'({out_z, out_tag, out_err}), 64'({32'h4000_0000, 4'd5, 1'b0}));
      chk("idle_hold_mul_a", 64'(mul_a), 64'h3F80_0000);
      step(); out_ready = 1'b1;
      step(); out_ready = 1'b0;
      @(negedge clk);
      chk("single_popped", 64'(out_valid), 64'd0);

      // Back-pressure: DEPTH+2 requests with out_ready held low for 30 cycles
      step();
      acc = 0; blocked = 0;
      set_req(4'(acc), 3'($urandom_range(0, 5)));
      for (int cyc = 0; cyc < 80 && acc < DEPTH + 2; cyc++) begin
         if (cyc == 30) begin
            chk("bp_accepted", 64'(acc), 64'(DEPTH));
            chk("bp_blocked", 64'(blocked), 64'(30 - DEPTH));
            chk("bp_head_tag", 64'(out_tag), 64'd0);
            out_ready = 1'b1;
         end
         @(negedge clk);
         acc_now = in_ready;
         if (!in_ready && cyc < 30) blocked++;
         step();
         if (acc_now) begin
            acc++;
            if (acc < DEPTH + 2) set_req(4'(acc), 3'($urandom_range(0, 5)));
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("bp_resumed", 64'(acc), 64'(DEPTH + 2));
      repeat (DEPTH + LAT + 4) step();
      chk("bp_drained", 64'(out_valid), 64'd0);

      // Streaming: 20 requests, out_ready high, expect one accept per cycle
      acc = 0; stalls = 0;
      set_req(4'(acc), 3'($urandom_range(0, 7)));
      for (int cyc = 0; cyc < 60 && acc < 20; cyc++) begin
         @(negedge clk);
         acc_now = in_ready;
         if (!in_ready) stalls++;
         step();
         if (acc_now) begin
            acc++;
            if (acc < 20) set_req(4'(acc), 3'($urandom_range(0, 7)));
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("stream_count", 64'(acc), 64'd20);
      chk("stream_stalls", 64'(stalls), 64'd0);
      repeat (LAT + 4) step();
      out_ready = 1'b0;

      // Simultaneous push and pop with two entries queued
      set_req(4'd10, 3'd1); step();                        // E0
      set_req(4'd11, 3'd2); step();                        // E1
      set_req(4'd12, 3'd3); step();                        // E2
      in_valid = 1'b0;
      step();                                              // E3: push 10
      step();                                              // E4: push 11
      out_ready = 1'b1;
      @(negedge clk);
      chk("pp_cnt_before", 64'(u_dut.w_fifo_cnt), 64'd2);
      chk("pp_head_before", 64'(out_tag), 64'd10);
      step(); out_ready = 1'b0;                            // E5: pop 10, push 12
      @(negedge clk);
      chk("pp_cnt_after", 64'(u_dut.w_fifo_cnt), 64'd2);
      chk("pp_head_after", 64'(out_tag), 64'd11);
      step(); out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;

      // Reset mid-operation: one queued result, three in flight
      set_req(4'd1, 3'd0); step();
      set_req(4'd2, 3'd0); step();
      set_req(4'd3, 3'd0); step();
      set_req(4'd4, 3'd0); step();
      in_valid = 1'b0;
      chk("mrst_pre_valid", 64'(out_valid), 64'd1);
      rst = 1'b0;
      #1;
      chk("mrst_valid_now", 64'(out_valid), 64'd0);
      chk("mrst_ready_now", 64'(in_ready), 64'd0);
      repeat (2) step();
      rst = 1'b1;
      #1;
      chk("mrst_ready_rel", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      seen = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mrst_no_stale", 64'(seen), 64'd0);
      step(); out_ready = 1'b0;

      // Rounding mode 7 following a normal request
      set_req(4'd1, 3'd0); a1 = in_a; step();
      set_req(4'd2, 3'd7); exp2 = expect_res(in_a, in_b, 3'd7, 4'd2); step();   // E0 of tag 2
      in_valid = 1'b0;
      @(negedge clk);
`ifdef FPM_RND_CHECK_EN
      chk("rnd7_issue", 64'(mul_issue), 64'd0);
      chk("rnd7_mul_hold", 64'(mul_a), 64'(a1));
`else
      chk("rnd7_issue", 64'(mul_issue), 64'd1);
      chk("rnd7_mul_rnd", 64'(mul_rnd), 64'd7);
`endif
      @(negedge clk);                                      // after E1
      @(negedge clk);                                      // after E2
      chk("rnd7_cnt_e2", 64'(u_dut.w_fifo_cnt), 64'd1);
      @(negedge clk);                                      // after E3
      chk("rnd7_cnt_e3", 64'(u_dut.w_fifo_cnt), 64'd2);
      step(); out_ready = 1'b1;
      step(); out_ready = 1'b0;
      @(negedge clk);
      chk("rnd7_head", 64'({out_z, out_status, out_tag, out_err}), 64'(exp2));
      step(); out_ready = 1'b1;
      repeat (4) step();

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
